// File: rtl/rot_pkg.sv
// Shared types and constants for the rotary quadrature controller.
// Holds FSM state encoding, AB Gray codes and the step-size lookup.
package rot_pkg;

    localparam int STEP_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6,
        ST_COOL = 3'd7
    } rot_state_e;

    localparam logic [1:0] AB_REST = 2'b11;
    localparam logic [1:0] AB_10   = 2'b10;
    localparam logic [1:0] AB_00   = 2'b00;
    localparam logic [1:0] AB_01   = 2'b01;

    function automatic logic [STEP_W-1:0] step_lookup(input logic [1:0] idx);
        logic [STEP_W-1:0] val;
        case (idx)
            2'd0:    val = 12'd1;
            2'd1:    val = 12'd10;
            2'd2:    val = 12'd100;
            2'd3:    val = 12'd1000;
            default: val = 12'd1;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/rot_sync_debounce.sv
// Input synchroniser with optional stable-level filter and rising-edge pulse.
// DEB_CYC=0 gives a plain synchroniser (level follows the last flop).
module rot_sync_debounce #(
    parameter int   SYNC_STG = 3,
    parameter int   DEB_CYC  = 0,
    parameter logic LVL_RST  = 1'b1
) (
    input  logic Fg_clk,
    input  logic Resetn,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [SYNC_STG-1:0] sync_r;
    logic                sync_s;

    assign sync_s = sync_r[SYNC_STG-1];

    // Synchroniser chain, idles high
    always_ff @(posedge Fg_clk) begin
        if (!Resetn) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STG-2:0], raw};
        end
    end

    if (DEB_CYC == 0) begin : g_raw
        logic prev_r;

        // Previous synchronised level for edge detection
        always_ff @(posedge Fg_clk) begin
            if (!Resetn) begin
                prev_r <= LVL_RST;
            end else begin
                prev_r <= sync_s;
            end
        end

        assign level = sync_s;
        assign rise  = sync_s & ~prev_r;
    end else begin : g_deb
        localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
        localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

        logic [CW-1:0] cnt_r;
        logic          level_r;
        logic          rise_r;

        // A new level is accepted only after DEB_CYC consecutive disagreeing samples
        always_ff @(posedge Fg_clk) begin
            if (!Resetn) begin
                cnt_r   <= '0;
                level_r <= LVL_RST;
                rise_r  <= 1'b0;
            end else if (sync_s != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_r   <= '0;
                    level_r <= sync_s;
                    rise_r  <= sync_s;
                end else begin
                    cnt_r  <= cnt_r + 1'b1;
                    rise_r <= 1'b0;
                end
            end else begin
                cnt_r  <= '0;
                rise_r <= 1'b0;
            end
        end

        assign level = level_r;
        assign rise  = rise_r;
    end

endmodule

// File: rtl/rotary_quad_ctrl.sv
// Quadrature rotary-encoder front-panel controller: Gray-code tracking FSM,
// clamped step counter, debounced step-size button and rate-limited address publish.
module rotary_quad_ctrl
    import rot_pkg::*;
#(
    parameter int CNT_W      = 11,
    parameter int CNT_MAX    = 1800,
    parameter int CNT_MIN    = 0,
    parameter int HI_MODE    = 4,
    parameter int HI_MIN     = 800,
    parameter int NUM_STEPS  = 3,
    parameter int SYNC_STG   = 3,
    parameter int DEB_CYC    = 1024,
    parameter int COOL_CYC   = 256,
    parameter int UPD_PERIOD = 2400,
    parameter int DIR_INV    = 0
) (
    input  logic             Fg_clk,
    input  logic             Resetn,
    input  logic [2:0]       Mode,
    input  logic             Rot_A,
    input  logic             Rot_B,
    input  logic             Rot_C,
    output logic [CNT_W-1:0] address,
    output logic             FreqChng,
    output logic [1:0]       step_idx,
    output logic             quad_err
);

    localparam int COOL_W = $clog2(COOL_CYC + 1);
    localparam int UPD_W  = $clog2(UPD_PERIOD + 1);

    localparam logic [CNT_W:0]    MAX_X     = (CNT_W + 1)'(CNT_MAX);
    localparam logic [CNT_W:0]    MIN_X     = (CNT_W + 1)'(CNT_MIN);
    localparam logic [CNT_W:0]    HI_MIN_X  = (CNT_W + 1)'(HI_MIN);
    localparam logic [2:0]        HI_MODE_C = 3'(HI_MODE);
    localparam logic [1:0]        STEP_LAST = 2'(NUM_STEPS - 1);
    localparam logic [COOL_W-1:0] COOL_END  = COOL_W'(COOL_CYC);
    localparam logic [UPD_W-1:0]  UPD_END   = UPD_W'(UPD_PERIOD);

    logic a_s, b_s, c_level_s, c_rise_s;
    logic a_rise_s, b_rise_s;
    logic unused_sig_s;
    logic [1:0] ab_s;

    rot_state_e state_r, state_nx;
    logic illegal_s, cw_commit_s, ccw_commit_s, inc_s, dec_s;
    logic [COOL_W-1:0] cool_cnt_r;
    logic cool_done_s;

    logic [CNT_W-1:0] count_r, count_nx;
    logic [CNT_W:0]   count_ext_s, step_s, lo_s, sum_s, diff_s, floor_s;
    logic             hi_mode_s;

    logic [1:0]       step_idx_r;
    logic [UPD_W-1:0] upd_cnt_r;
    logic             change_s;
    logic [CNT_W-1:0] address_r;
    logic             freq_chng_r;
    logic             quad_err_r;

    rot_sync_debounce #(.SYNC_STG(SYNC_STG), .DEB_CYC(0), .LVL_RST(1'b1)) u_sync_a (
        .Fg_clk(Fg_clk), .Resetn(Resetn), .raw(Rot_A), .level(a_s), .rise(a_rise_s)
    );

    rot_sync_debounce #(.SYNC_STG(SYNC_STG), .DEB_CYC(0), .LVL_RST(1'b1)) u_sync_b (
        .Fg_clk(Fg_clk), .Resetn(Resetn), .raw(Rot_B), .level(b_s), .rise(b_rise_s)
    );

    // Button filter level starts released so the idle-high synchroniser cannot fake a press
    rot_sync_debounce #(.SYNC_STG(SYNC_STG), .DEB_CYC(DEB_CYC), .LVL_RST(1'b0)) u_deb_c (
        .Fg_clk(Fg_clk), .Resetn(Resetn), .raw(Rot_C), .level(c_level_s), .rise(c_rise_s)
    );

    assign unused_sig_s = a_rise_s ^ b_rise_s ^ c_level_s;
    assign ab_s         = {a_s, b_s};
    assign cool_done_s  = (cool_cnt_r >= COOL_END);

    // FSM state register
    always_ff @(posedge Fg_clk) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Gray-code tracking: neighbour codes move, the opposite code is illegal
    always_comb begin
        state_nx     = state_r;
        illegal_s    = 1'b0;
        cw_commit_s  = 1'b0;
        ccw_commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                case (ab_s)
                    AB_10:   state_nx = ST_CW1;
                    AB_01:   state_nx = ST_CCW1;
                    AB_00:   begin illegal_s = 1'b1; state_nx = ST_COOL; end
                    default: state_nx = ST_IDLE;
                endcase
            end
            ST_CW1: begin
                case (ab_s)
                    AB_00:   state_nx = ST_CW2;
                    AB_REST: state_nx = ST_IDLE;
                    AB_01:   begin illegal_s = 1'b1; state_nx = ST_COOL; end
                    default: state_nx = ST_CW1;
                endcase
            end
            ST_CW2: begin
                case (ab_s)
                    AB_01:   state_nx = ST_CW3;
                    AB_10:   state_nx = ST_CW1;
                    AB_REST: begin illegal_s = 1'b1; state_nx = ST_COOL; end
                    default: state_nx = ST_CW2;
                endcase
            end
            ST_CW3: begin
                case (ab_s)
                    AB_REST: begin cw_commit_s = 1'b1; state_nx = ST_COOL; end
                    AB_00:   state_nx = ST_CW2;
                    AB_10:   begin illegal_s = 1'b1; state_nx = ST_COOL; end
                    default: state_nx = ST_CW3;
                endcase
            end
            ST_CCW1: begin
                case (ab_s)
                    AB_00:   state_nx = ST_CCW2;
                    AB_REST: state_nx = ST_IDLE;
                    AB_10:   begin illegal_s = 1'b1; state_nx = ST_COOL; end
                    default: state_nx = ST_CCW1;
                endcase
            end
            ST_CCW2: begin
                case (ab_s)
                    AB_10:   state_nx = ST_CCW3;
                    AB_01:   state_nx = ST_CCW1;
                    AB_REST: begin illegal_s = 1'b1; state_nx = ST_COOL; end
                    default: state_nx = ST_CCW2;
                endcase
            end
            ST_CCW3: begin
                case (ab_s)
                    AB_REST: begin ccw_commit_s = 1'b1; state_nx = ST_COOL; end
                    AB_00:   state_nx = ST_CCW2;
                    AB_01:   begin illegal_s = 1'b1; state_nx = ST_COOL; end
                    default: state_nx = ST_CCW3;
                endcase
            end
            ST_COOL: begin
                if (cool_done_s && (ab_s == AB_REST)) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_COOL;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Lockout timer: saturates at COOL_CYC, cleared on leaving COOL
    always_ff @(posedge Fg_clk) begin
        if (!Resetn) begin
            cool_cnt_r <= '0;
        end else if (state_r != ST_COOL) begin
            cool_cnt_r <= '0;
        end else if (state_nx != ST_COOL) begin
            cool_cnt_r <= '0;
        end else if (!cool_done_s) begin
            cool_cnt_r <= cool_cnt_r + 1'b1;
        end else begin
            cool_cnt_r <= cool_cnt_r;
        end
    end

    assign inc_s       = (DIR_INV != 0) ? ccw_commit_s : cw_commit_s;
    assign dec_s       = (DIR_INV != 0) ? cw_commit_s : ccw_commit_s;
    assign hi_mode_s   = (Mode == HI_MODE_C);
    assign count_ext_s = {1'b0, count_r};
    assign step_s      = (CNT_W + 1)'(step_lookup(step_idx_r));
    assign lo_s        = hi_mode_s ? HI_MIN_X : MIN_X;
    assign sum_s       = count_ext_s + step_s;
    assign diff_s      = count_ext_s - step_s;
    assign floor_s     = lo_s + step_s;

    // Clamped commit arithmetic; the restricted-range floor overrides any commit
    always_comb begin
        count_nx = count_r;
        if (hi_mode_s && (count_ext_s < HI_MIN_X)) begin
            count_nx = HI_MIN_X[CNT_W-1:0];
        end else if (inc_s) begin
            if (sum_s > MAX_X) begin
                count_nx = MAX_X[CNT_W-1:0];
            end else begin
                count_nx = sum_s[CNT_W-1:0];
            end
        end else if (dec_s) begin
            if (count_ext_s < floor_s) begin
                count_nx = lo_s[CNT_W-1:0];
            end else begin
                count_nx = diff_s[CNT_W-1:0];
            end
        end else begin
            count_nx = count_r;
        end
    end

    // Count, step index and error pulse registers
    always_ff @(posedge Fg_clk) begin
        if (!Resetn) begin
            count_r    <= '0;
            step_idx_r <= 2'd0;
            quad_err_r <= 1'b0;
        end else begin
            count_r    <= count_nx;
            quad_err_r <= illegal_s;
            if (c_rise_s) begin
                step_idx_r <= (step_idx_r == STEP_LAST) ? 2'd0 : step_idx_r + 2'd1;
            end else begin
                step_idx_r <= step_idx_r;
            end
        end
    end

    assign change_s = (upd_cnt_r == UPD_END);

    // Publish the count at a fixed rate, flagging real changes
    always_ff @(posedge Fg_clk) begin
        if (!Resetn) begin
            upd_cnt_r   <= '0;
            address_r   <= '0;
            freq_chng_r <= 1'b0;
        end else begin
            freq_chng_r <= change_s && (address_r != count_r);
            if (change_s) begin
                upd_cnt_r <= '0;
                address_r <= count_r;
            end else begin
                upd_cnt_r <= upd_cnt_r + 1'b1;
                address_r <= address_r;
            end
        end
    end

    assign address  = address_r;
    assign FreqChng = freq_chng_r;
    assign step_idx = step_idx_r;
    assign quad_err = quad_err_r;

endmodule

// File: tb/tb_rotary_quad_ctrl.sv
// Scoreboard bench for rotary_quad_ctrl: stimulus queues expected published
// addresses and error pulses, a monitor consumes them on FreqChng / quad_err.
module tb_rotary_quad_ctrl;

    localparam int STROBE = 2401;

    logic        Fg_clk = 1'b0;
    logic        Resetn = 1'b0;
    logic [2:0]  Mode   = 3'd0;
    logic        Rot_A  = 1'b1;
    logic        Rot_B  = 1'b1;
    logic        Rot_C  = 1'b0;
    logic [10:0] address;
    logic        FreqChng;
    logic [1:0]  step_idx;
    logic        quad_err;

    int total = 0;
    int bad   = 0;
    int since_rst = 0;
    logic [10:0] addr_q[$];
    logic        err_q[$];
    logic [10:0] exp_addr = 11'd0;

    rotary_quad_ctrl dut (
        .Fg_clk(Fg_clk), .Resetn(Resetn), .Mode(Mode),
        .Rot_A(Rot_A), .Rot_B(Rot_B), .Rot_C(Rot_C),
        .address(address), .FreqChng(FreqChng),
        .step_idx(step_idx), .quad_err(quad_err)
    );

    always #5 Fg_clk = ~Fg_clk;

    // Edges since the last reset edge; strobes land on multiples of STROBE
    always @(posedge Fg_clk) begin
        if (!Resetn) since_rst <= 0;
        else         since_rst <= since_rst + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: consume expected responses when the DUT presents them
    initial begin
        forever begin
            @(negedge Fg_clk);
            if (FreqChng === 1'b1) begin
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL freqchng_unexpected: address=%0d with empty queue", address);
                end else begin
                    logic [10:0] e;
                    e = addr_q.pop_front();
                    if (address !== e) begin
                        bad++;
                        $display("FAIL published_addr: got %0d expected %0d", address, e);
                    end
                end
            end
            if (quad_err === 1'b1) begin
                total++;
                if (err_q.size() == 0) begin
                    bad++;
                    $display("FAIL quad_err_unexpected: pulse with no expected error");
                end else begin
                    void'(err_q.pop_front());
                end
            end
        end
    end

    task automatic publish(input logic [10:0] v);
        addr_q.push_back(v);
        exp_addr = v;
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge Fg_clk);
            n++;
        end while (!((since_rst % STROBE) == 0 && since_rst != 0) && n < 2 * STROBE);
        @(negedge Fg_clk);
        check("addr_pending", addr_q.size(), 0);
        check("err_pending", err_q.size(), 0);
        check("address", int'(address), int'(exp_addr));
    endtask

    task automatic drive_ab(input logic [1:0] ab, input int n);
        @(negedge Fg_clk);
        Rot_A = ab[1];
        Rot_B = ab[0];
        repeat (n - 1) @(negedge Fg_clk);
    endtask

    task automatic cw_detent();
        drive_ab(2'b10, 20); drive_ab(2'b00, 20); drive_ab(2'b01, 20); drive_ab(2'b11, 300);
    endtask

    task automatic ccw_detent();
        drive_ab(2'b01, 20); drive_ab(2'b00, 20); drive_ab(2'b10, 20); drive_ab(2'b11, 300);
    endtask

    task automatic press(input int exp_idx);
        @(negedge Fg_clk);
        Rot_C = 1'b1;
        repeat (1100) @(negedge Fg_clk);
        check("step_idx_press", int'(step_idx), exp_idx);
        Rot_C = 1'b0;
        repeat (1100) @(negedge Fg_clk);
    endtask

    initial begin
        repeat (4) @(negedge Fg_clk);
        check("rst_address", int'(address), 0);
        check("rst_freqchng", int'(FreqChng), 0);
        check("rst_step_idx", int'(step_idx), 0);
        check("rst_quad_err", int'(quad_err), 0);
        Resetn = 1'b1;

        cw_detent();                                  publish(11'd1);    wait_strobe();
        repeat (4) cw_detent();                       publish(11'd5);    wait_strobe();
        press(1);                                                        wait_strobe();
        repeat (2) cw_detent();                       publish(11'd25);   wait_strobe();
        repeat (3) ccw_detent();                      publish(11'd0);    wait_strobe();
        press(2);                                                        wait_strobe();
        repeat (3) cw_detent();                       publish(11'd300);  wait_strobe();

        // Restricted range lifts the floor, then a CCW detent is clamped at it
        @(negedge Fg_clk); Mode = 3'd4;
        repeat (3) @(negedge Fg_clk);
        ccw_detent();                                 publish(11'd800);  wait_strobe();
        repeat (5) cw_detent();                       publish(11'd1300); wait_strobe();
        repeat (5) cw_detent();                       publish(11'd1800); wait_strobe();

        // Saturated detent and a reversed partial detent: no published change
        cw_detent();
        drive_ab(2'b10, 20); drive_ab(2'b00, 20); drive_ab(2'b10, 20); drive_ab(2'b11, 40);
        wait_strobe();

        // Illegal jumps from IDLE and from CW1, then a normal detent after lockout
        err_q.push_back(1'b1);
        drive_ab(2'b00, 20); drive_ab(2'b11, 300);
        err_q.push_back(1'b1);
        drive_ab(2'b10, 20); drive_ab(2'b01, 20); drive_ab(2'b11, 300);
        ccw_detent();                                 publish(11'd1700); wait_strobe();

        // Bouncing button: one advance only, wrapping 2 -> 0
        for (int i = 0; i < 50; i++) begin
            @(negedge Fg_clk);
            Rot_C = ~Rot_C;
            repeat (9) @(negedge Fg_clk);
        end
        Rot_C = 1'b1;
        repeat (1100) @(negedge Fg_clk);
        check("step_idx_bounce", int'(step_idx), 0);
        Rot_C = 1'b0;
        repeat (1100) @(negedge Fg_clk);
        wait_strobe();
        ccw_detent();                                 publish(11'd1699); wait_strobe();
        press(1);                                                        wait_strobe();
        ccw_detent();                                 publish(11'd1689); wait_strobe();

        // Reset in the middle of a CW detent
        drive_ab(2'b10, 20); drive_ab(2'b00, 20);
        @(negedge Fg_clk); Resetn = 1'b0;
        @(negedge Fg_clk);
        check("midrst_address", int'(address), 0);
        check("midrst_freqchng", int'(FreqChng), 0);
        check("midrst_step_idx", int'(step_idx), 0);
        check("midrst_quad_err", int'(quad_err), 0);
        Rot_A = 1'b1; Rot_B = 1'b1; Mode = 3'd0;
        exp_addr = 11'd0;
        repeat (3) @(negedge Fg_clk);
        Resetn = 1'b1;
        cw_detent();                                  publish(11'd1);    wait_strobe();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
